// File: rtl/clock_pkg.sv
// Shared types and default sizing for the PLL synthesizer serial programming path.
package clock_pkg;

  localparam int WORD_W_DEF  = 32;
  localparam int CLK_DIV_DEF = 2;
  localparam int LE_W_DEF    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: one-cycle tick on every CLK_DIV-th enabled cycle.
module spi_tick_gen
  import clock_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rset,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Reloads whenever disabled so the first enabled cycle starts a full half-period.
  always_ff @(posedge clk) begin
    if (rset) begin
      cnt <= '0;
    end else if (!en || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/pll_spi_tx.sv
// Serial word transmitter for PLL synthesizer programming: MSB-first shift, then le pulse.
//   state    | meaning
//   ST_IDLE  | waiting for a word; word_ready high, done high on first cycle back
//   ST_SHIFT | clocking bits out, 2*CLK_DIV cycles per bit (sclk low then high)
//   ST_LATCH | sclk low, le high for LE_W cycles
module pll_spi_tx
  import clock_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int LE_W    = LE_W_DEF
) (
  input  logic              clk,
  input  logic              rset,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              sdo,
  output logic              sclk,
  output logic              le,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(WORD_W + 1);
  localparam int LW = $clog2(LE_W + 1);

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic [LW-1:0]     le_cnt;
  logic              phase;
  logic              done_r;
  logic              tick;
  logic              accept;
  logic              last_tick;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rset (rset),
    .en   (state == ST_SHIFT),
    .tick (tick)
  );

  assign accept    = word_valid && word_ready;
  assign last_tick = tick && phase && (bit_cnt == BW'(1));

  always_ff @(posedge clk) begin
    if (rset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)         state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_tick)      state_nxt = ST_LATCH;
      ST_LATCH: if (le_cnt == '0)   state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // phase low = sclk low half; the shift happens as the high half ends, so sdo moves with sclk low.
  always_ff @(posedge clk) begin
    if (rset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      le_cnt  <= '0;
      phase   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= (state == ST_LATCH) && (le_cnt == '0);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg   <= word_data;
            bit_cnt <= BW'(WORD_W);
            phase   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            phase <= !phase;
            if (phase) begin
              shreg   <= {shreg[WORD_W-2:0], 1'b0};
              bit_cnt <= bit_cnt - BW'(1);
              if (bit_cnt == BW'(1)) le_cnt <= LW'(LE_W - 1);
            end
          end
        end
        ST_LATCH: begin
          if (le_cnt != '0) le_cnt <= le_cnt - LW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    word_ready = 1'b0;
    sdo        = 1'b0;
    sclk       = 1'b0;
    le         = 1'b0;
    busy       = 1'b0;
    done       = done_r;
    case (state)
      ST_IDLE:  word_ready = !rset;
      ST_SHIFT: begin
        busy = 1'b1;
        sdo  = shreg[WORD_W-1];
        sclk = phase;
      end
      ST_LATCH: begin
        busy = 1'b1;
        le   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pll_spi_tx.sv
// Directed bench for pll_spi_tx: default instance plus a minimum-configuration instance.
module tb_pll_spi_tx;

  logic        clk = 1'b0;
  logic        rset;
  logic [31:0] data0;
  logic        valid0;
  logic        ready0, sdo0, sclk0, le0, busy0, done0;
  logic [7:0]  data1;
  logic        valid1;
  logic        ready1, sdo1, sclk1, le1, busy1, done1;

  int checks = 0;
  int fails  = 0;

  pll_spi_tx u_dut0 (
    .clk        (clk),
    .rset       (rset),
    .word_data  (data0),
    .word_valid (valid0),
    .word_ready (ready0),
    .sdo        (sdo0),
    .sclk       (sclk0),
    .le         (le0),
    .busy       (busy0),
    .done       (done0)
  );

  pll_spi_tx #(.WORD_W(8), .CLK_DIV(1), .LE_W(1)) u_dut1 (
    .clk        (clk),
    .rset       (rset),
    .word_data  (data1),
    .word_valid (valid1),
    .word_ready (ready1),
    .sdo        (sdo1),
    .sclk       (sclk1),
    .le         (le1),
    .busy       (busy1),
    .done       (done1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observes one DUT from its acceptance cycle (cycle 0) until the final done.
  task automatic measure(input bit which, input int mode, input int max_cyc,
                         output logic [63:0] rx, output int edges, output int le_first,
                         output int le_n, output int done_a, output int done_b,
                         output int stab_bad, output int ready_bad, output int gap_bad,
                         output bit rdy0);
    logic ps, pd, s_sclk, s_sdo, s_le, s_done, s_rdy, s_busy;
    int   ndone;
    rx = '0; edges = 0; le_first = -1; le_n = 0; done_a = -1; done_b = -1;
    stab_bad = 0; ready_bad = 0; gap_bad = 0; rdy0 = 1'b0;
    ps = 1'b0; pd = 1'b0; ndone = 0;
    for (int c = 0; c <= max_cyc; c++) begin
      @(negedge clk);
      s_sclk = which ? sclk1  : sclk0;
      s_sdo  = which ? sdo1   : sdo0;
      s_le   = which ? le1    : le0;
      s_done = which ? done1  : done0;
      s_rdy  = which ? ready1 : ready0;
      s_busy = which ? busy1  : busy0;
      if (c == 0) rdy0 = s_rdy;
      if (s_sclk && !ps) begin
        edges++;
        rx = {rx[62:0], s_sdo};
      end
      if (s_sclk && ps && (s_sdo !== pd)) stab_bad++;
      if (s_le) begin
        if (le_first < 0) le_first = c;
        le_n++;
      end
      if (c > 0 && s_rdy && !s_done) ready_bad++;
      if (c > 0 && !s_busy && !s_done) gap_bad++;
      if (s_done) begin
        ndone++;
        if (ndone == 1) done_a = c;
        else done_b = c;
      end
      ps = s_sclk;
      pd = s_sdo;
      if (ndone == ((mode == 1) ? 2 : 1)) break;
      @(posedge clk); #1;
      case (mode)
        0: begin valid0 = 1'b0; valid1 = 1'b0; end
        1: begin
          if (c == 0) data0 = 32'h8000_0000;
          if (ndone == 1) valid0 = 1'b0;
        end
        2: begin
          data0 = ~data0;
          if (s_le) valid0 = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    rset = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ready0, ready1} !== 2'b00) begin
      fails++; $display("FAIL reset_ready: got %b expected 00", {ready0, ready1});
    end
    checks++;
    if ({sdo0, sclk0, le0, busy0, done0, sdo1, sclk1, le1, busy1, done1} !== 10'b0) begin
      fails++; $display("FAIL reset_outputs: got %b expected 0",
                        {sdo0, sclk0, le0, busy0, done0, sdo1, sclk1, le1, busy1, done1});
    end
    @(posedge clk); #1;
    rset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready0, ready1} !== 2'b11) begin
      fails++; $display("FAIL reset_release_ready: got %b expected 11", {ready0, ready1});
    end
  endtask

  task automatic test_single_word();
    logic [63:0] rx; int edges, lf, ln, da, db, sb, rb, gb; bit r0;
    @(posedge clk); #1;
    data0 = 32'hA5F0_0013; valid0 = 1'b1;
    measure(1'b0, 0, 200, rx, edges, lf, ln, da, db, sb, rb, gb, r0);
    checks++; if (r0 !== 1'b1) begin fails++; $display("FAIL single_accept: got %b expected 1", r0); end
    checks++; if (rx[31:0] !== 32'hA5F0_0013) begin fails++; $display("FAIL single_data: got %h expected a5f00013", rx[31:0]); end
    checks++; if (edges !== 32) begin fails++; $display("FAIL single_edges: got %0d expected 32", edges); end
    checks++; if (lf !== 129) begin fails++; $display("FAIL single_le_first: got %0d expected 129", lf); end
    checks++; if (ln !== 2) begin fails++; $display("FAIL single_le_len: got %0d expected 2", ln); end
    checks++; if (da !== 131) begin fails++; $display("FAIL single_done: got %0d expected 131", da); end
    checks++; if (sb !== 0) begin fails++; $display("FAIL single_sdo_stable: got %0d changes expected 0", sb); end
    checks++; if (gb !== 0) begin fails++; $display("FAIL single_busy: got %0d idle cycles expected 0", gb); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rx; int edges, lf, ln, da, db, sb, rb, gb; bit r0;
    @(posedge clk); #1;
    data0 = 32'h0000_0001; valid0 = 1'b1;
    measure(1'b0, 1, 400, rx, edges, lf, ln, da, db, sb, rb, gb, r0);
    checks++; if (rx !== {32'h0000_0001, 32'h8000_0000}) begin fails++; $display("FAIL b2b_data: got %h expected 0000000180000000", rx); end
    checks++; if (edges !== 64) begin fails++; $display("FAIL b2b_edges: got %0d expected 64", edges); end
    checks++; if (da !== 131) begin fails++; $display("FAIL b2b_done1: got %0d expected 131", da); end
    checks++; if (db !== 262) begin fails++; $display("FAIL b2b_done2: got %0d expected 262", db); end
    checks++; if (ln !== 4) begin fails++; $display("FAIL b2b_le_len: got %0d expected 4", ln); end
    checks++; if (gb !== 0) begin fails++; $display("FAIL b2b_gap: got %0d idle cycles expected 0", gb); end
  endtask

  task automatic test_busy_inputs();
    logic [63:0] rx; int edges, lf, ln, da, db, sb, rb, gb; bit r0;
    @(posedge clk); #1;
    data0 = 32'h1234_5678; valid0 = 1'b1;
    measure(1'b0, 2, 200, rx, edges, lf, ln, da, db, sb, rb, gb, r0);
    valid0 = 1'b0;
    checks++; if (rx[31:0] !== 32'h1234_5678) begin fails++; $display("FAIL busy_data: got %h expected 12345678", rx[31:0]); end
    checks++; if (rb !== 0) begin fails++; $display("FAIL busy_ready_low: got %0d ready cycles expected 0", rb); end
    checks++; if (da !== 131) begin fails++; $display("FAIL busy_done: got %0d expected 131", da); end
  endtask

  task automatic test_reset_mid_shift();
    int   e = 0;
    int   hit = -1;
    int   bad = 0;
    logic ps = 1'b0;
    @(posedge clk); #1;
    data0 = 32'hDEAD_BEEF; valid0 = 1'b1;
    for (int c = 0; c <= 200; c++) begin
      @(negedge clk);
      if (sclk0 && !ps) e++;
      ps = sclk0;
      if (e == 10) begin hit = c; break; end
      @(posedge clk); #1;
      valid0 = 1'b0;
    end
    checks++; if (hit !== 39) begin fails++; $display("FAIL rst_edge10_cycle: got %0d expected 39", hit); end
    @(posedge clk); #1;
    rset = 1'b1;
    @(negedge clk);
    checks++; if (ready0 !== 1'b0) begin fails++; $display("FAIL rst_ready_during: got %b expected 0", ready0); end
    @(posedge clk); #1;
    rset = 1'b0;
    @(negedge clk);
    checks++;
    if ({sdo0, sclk0, le0, busy0, done0} !== 5'b0) begin
      fails++; $display("FAIL rst_outputs_cleared: got %b expected 00000", {sdo0, sclk0, le0, busy0, done0});
    end
    checks++; if (ready0 !== 1'b1) begin fails++; $display("FAIL rst_ready_after: got %b expected 1", ready0); end
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (le0 || done0 || sclk0) bad++;
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL rst_abandoned: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_min_config();
    logic [63:0] rx; int edges, lf, ln, da, db, sb, rb, gb; bit r0;
    @(posedge clk); #1;
    data1 = 8'h3C; valid1 = 1'b1;
    measure(1'b1, 0, 60, rx, edges, lf, ln, da, db, sb, rb, gb, r0);
    checks++; if (rx[7:0] !== 8'h3C) begin fails++; $display("FAIL min_data: got %h expected 3c", rx[7:0]); end
    checks++; if (edges !== 8) begin fails++; $display("FAIL min_edges: got %0d expected 8", edges); end
    checks++; if (lf !== 17) begin fails++; $display("FAIL min_le_first: got %0d expected 17", lf); end
    checks++; if (ln !== 1) begin fails++; $display("FAIL min_le_len: got %0d expected 1", ln); end
    checks++; if (da !== 18) begin fails++; $display("FAIL min_done: got %0d expected 18", da); end
  endtask

  initial begin
    rset   = 1'b1;
    data0  = '0;
    valid0 = 1'b0;
    data1  = '0;
    valid1 = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_busy_inputs();
    test_reset_mid_shift();
    test_min_config();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pll_spi_tx.md
PLL_SPI_TX -- requirements
Module: pll_spi_tx

Interface
REQ-001 SHALL have parameter WORD_W, default 32, serial word length in bits (legal 8..32).
REQ-002 SHALL have parameter CLK_DIV, default 2, clk cycles per sclk half-period (legal >= 1).
REQ-003 SHALL have parameter LE_W, default 2, clk cycles le is held high per word (legal >= 1).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port word_data  input  WORD_W  configuration word to send, MSB first.
REQ-007 SHALL have port word_valid  input  1  word_data is valid.
REQ-008 SHALL have port word_ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have port sdo  output  1  serial data to the synthesizer.
REQ-010 SHALL have port sclk  output  1  serial clock to the synthesizer.
REQ-011 SHALL have port le  output  1  latch enable; high pulse after the last bit.
REQ-012 SHALL have port busy  output  1  high from the cycle after acceptance until the return to IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse marking word completion.

Function
REQ-014 SHALL implement states IDLE, SHIFT and LATCH.
REQ-015 SHALL drive word_ready high only in IDLE while rset is low.
REQ-016 SHALL accept a word on the cycle with word_valid && word_ready (cycle 0), capture word_data into a shift register, and enter SHIFT at cycle 1.
REQ-017 SHALL ignore word_valid and word_data changes outside IDLE; a captured word is unaffected by later input changes.
REQ-018 SHALL, in SHIFT, drive each bit for 2*CLK_DIV cycles: sclk low for the first CLK_DIV cycles, then high for the next CLK_DIV cycles.
REQ-019 SHALL change sdo only while sclk is low, so sdo is stable across every sclk rising edge.
REQ-020 SHALL present bit WORD_W-1 first, with sdo valid from cycle 1.
REQ-021 SHALL produce exactly WORD_W sclk rising edges per word; shift occupies cycles 1..2*CLK_DIV*WORD_W.
REQ-022 SHALL return sclk low on leaving SHIFT, enter LATCH, and hold le high for LE_W cycles with sclk low.
REQ-023 SHALL return to IDLE after LATCH and assert done for exactly the first IDLE cycle.
REQ-024 SHALL allow a new word to be accepted in the same cycle done is high, giving back-to-back operation.
REQ-025 SHALL give a per-word period of 1 + 2*CLK_DIV*WORD_W + LE_W cycles from acceptance to the done cycle inclusive.
REQ-026 SHALL keep le low in IDLE and SHIFT, sclk low in IDLE and LATCH, and sdo low in IDLE.
REQ-027 SHALL use a half-period counter of width ceil(log2(CLK_DIV+1)) and a bit counter of width ceil(log2(WORD_W+1)); neither counter may wrap inside a word.

Reset
REQ-028 SHALL, while rset is high at a clk edge, force state IDLE, sdo=0, sclk=0, le=0, busy=0, done=0, and clear all counters and the shift register.
REQ-029 SHALL drive word_ready low in any cycle rset is high.
REQ-030 SHALL, on reset mid-word (SHIFT or LATCH), abandon the word without asserting le or done and without emitting further sclk edges.

Structure
REQ-031 SHALL take the state encoding and the default values of WORD_W, CLK_DIV and LE_W from the shared package clock_pkg.
REQ-032 SHALL place the half-period counter in a sub-module spi_tick_gen, which outputs a one-cycle tick every CLK_DIV cycles while enabled and is cleared by rset.

Verification
REQ-033 SHALL cover a single word: defaults, word_data=0xA5F00013 accepted at cycle 0 -> 32 sclk rising edges sample 0xA5F00013 MSB first; le high cycles 129-130; done cycle 131.
REQ-034 SHALL cover back-to-back words: word_valid held high with 0x00000001 then 0x80000000 -> second word accepted in the first word's done cycle; no idle gap; both words sampled correctly.
REQ-035 SHALL cover reset mid-shift: rset pulsed for 1 cycle after the 10th sclk rising edge -> next cycle all outputs 0; no le or done; word_ready high the cycle after rset falls.
REQ-036 SHALL cover input changes while busy: word_data toggled every cycle and word_valid held high during SHIFT -> transmitted bits equal the captured word and word_ready stays low until done.
REQ-037 SHALL cover the minimum configuration: CLK_DIV=1, WORD_W=8, LE_W=1, word 0x3C -> sclk toggles every cycle, 8 edges sample 0x3C, le high at cycle 17, done at cycle 18.
